debug_mem_dump: RTL and testbench
=================================

// Module: debug_mem_dump
// PURPOSE
//  Debug-side reader for the byte-wide data memory written by the MEM stage.
//  On command, reads a contiguous byte range and streams it out over a valid/ready byte interface (feeds UART TX).
//  Runs only while the debug unit holds the pipeline halted; it does not arbitrate against MEM-stage writes.
// PARAMETERS
//  ADDR_WIDTH  12  byte-address width of data memory (4K bytes)
// PORTS
//  i_clk        in   1             clock; all state updates on rising edge
//  i_reset      in   1             synchronous, active-high reset
//  i_start      in   1             one-cycle dump request; sampled only in IDLE
//  i_base_addr  in   ADDR_WIDTH    first byte address; latched on accepted start
//  i_length     in   ADDR_WIDTH+1  byte count, 0..2^ADDR_WIDTH; latched on accepted start
//  o_mem_addr   out  ADDR_WIDTH    read address to memory async-read port (= address register)
//  i_mem_data   in   8             async read data for o_mem_addr, same cycle
//  o_tx_data    out  8             byte to transmit
//  o_tx_valid   out  1             byte available
//  i_tx_ready   in   1             sink accepts byte when valid&&ready at clock edge
//  o_busy       out  1             high in any state but IDLE
//  o_done       out  1             one-cycle pulse at end of dump
// BEHAVIOUR
//  Reset: state=IDLE, addr=0, count=0, o_tx_data=0x00, o_tx_valid=0, o_busy=0, o_done=0, checksum=0x00.
//  FSM states: IDLE, READ, SEND, [CHK], DONE.
//  IDLE: if i_start: latch addr=i_base_addr, count=i_length, clear checksum.
//   Next state is READ when count!=0, DONE when count==0.
//  READ: o_tx_data<=i_mem_data (mem at addr), checksum^=i_mem_data; -> SEND.
//  SEND: o_tx_valid=1; hold while !i_tx_ready (o_tx_data, addr, count stable).
//   On accept: addr<=addr+1 (mod 2^ADDR_WIDTH, wraps 0xFFF->0x000), count<=count-1.
//   Then if count==1 -> CHK (macro on) / DONE (macro off); else -> READ.
//  DONE: o_done=1 for exactly this cycle; -> IDLE.
//  o_tx_valid, o_busy, o_done are decodes of the registered state; no combinational path from inputs.
//  Throughput: 2 cycles/byte when ready is tied high.
//   Start sampled at cycle 0 -> first valid at cycle 2.
//  i_start outside IDLE is ignored; no queuing.
//  i_reset mid-dump: abort immediately to reset values; a byte pending in SEND is dropped.
//  i_length > 2^ADDR_WIDTH is not legal; behaviour is unspecified.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined: after the last data byte, state CHK drives o_tx_data=checksum.
//   The checksum is the XOR of all sent bytes. o_tx_valid=1; on accept -> DONE.
//   A length-0 dump sends no checksum.
//  Not defined: CHK state and checksum register absent; SEND -> DONE directly.
// TESTING
//  1 mem[0x010..0x013]=11,22,33,44; start base=0x010 len=4, ready=1
//    -> bytes 11,22,33,44 on valid cycles 2,4,6,8; o_done at cycle 9 (macro off).
//  2 same as 1 with DUMP_CHECKSUM_EN -> 5th byte 0x44 at cycle 9; o_done at cycle 10.
//  3 mem[0xFFE]=AA,[0xFFF]=BB,[0x000]=CC,[0x001]=DD; base=0xFFE len=4
//    -> AA,BB,CC,DD (address wrap).
//  4 len=2, ready low 5 cycles during first SEND
//    -> valid and data held stable, o_mem_addr unchanged; resumes on ready, 2 bytes total.
//  5 len=0 start -> no valid ever; o_busy cycle 1 only, o_done cycle 1 (also with macro).
//  6 start pulse mid-dump ignored; i_reset in SEND
//    -> next cycle all outputs at reset values; new start works normally.

Source files
------------

// File: rtl/debug_mem_dump_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_mem_dump_if
//  Description : Command, memory read port and byte-stream signals of the
//                debug memory dumper, bundled as one interface.
//                slave  = the dumper, master = the controller/memory/sink side.
//  Revision    : 1.0  initial release
// ============================================================================
interface debug_mem_dump_if #(
    parameter int ADDR_WIDTH = 12
);
    // command
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [ADDR_WIDTH:0]   i_length;
    // asynchronous memory read port
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [7:0]            i_mem_data;
    // byte stream towards the UART transmitter
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    // status
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_base_addr, i_length, i_mem_data, i_tx_ready,
        output o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_base_addr, i_length, i_mem_data, i_tx_ready,
        input  o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/debug_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : debug_mem_dump
//  Description : Reads a contiguous byte range of the data memory while the
//                pipeline is halted and streams it over a valid/ready byte
//                interface, two cycles per byte with ready tied high.
//                Optional feature macro: DUMP_CHECKSUM_EN appends one XOR
//                checksum byte after the data of a non-empty dump.
//  Revision    : 1.0  initial release
// ============================================================================
module debug_mem_dump #(
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    debug_mem_dump_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
        ST_CHK  = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]   c_count_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [7:0]            r_tx_data;
    logic                  w_accept;
    logic                  w_last;

`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            r_checksum;
`endif

    // A byte leaves only from SEND when the sink is ready at the edge.
    assign w_accept = (r_state == ST_SEND) && bus.i_tx_ready;
    assign w_last   = (r_count == c_count_one);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is honoured only in IDLE, so a pulse during a dump is lost.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_next_state = (bus.i_length != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (bus.i_tx_ready) begin
                    if (w_last) begin
`ifdef DUMP_CHECKSUM_EN
                        w_next_state = ST_CHK;
`else
                        w_next_state = ST_DONE;
`endif
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHK: begin
                if (bus.i_tx_ready) begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address/count/data registers; everything is held while SEND waits for ready.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr    <= '0;
            r_count   <= '0;
            r_tx_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_addr  <= bus.i_base_addr;
                        r_count <= bus.i_length;
                    end
                end
                ST_READ: begin
                    r_tx_data <= bus.i_mem_data;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        // Address wraps naturally at the top of memory.
                        r_addr  <= r_addr + c_addr_one;
                        r_count <= r_count - c_count_one;
`ifdef DUMP_CHECKSUM_EN
                        // The checksum already includes the byte being accepted.
                        if (w_last) begin
                            r_tx_data <= r_checksum;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every byte fetched in this dump; cleared on an accepted start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_checksum <= 8'h00;
        end else if ((r_state == ST_IDLE) && bus.i_start) begin
            r_checksum <= 8'h00;
        end else if (r_state == ST_READ) begin
            r_checksum <= r_checksum ^ bus.i_mem_data;
        end
    end
`endif

    // Outputs are pure decodes of registered state.
    assign bus.o_mem_addr = r_addr;
    assign bus.o_tx_data  = r_tx_data;
`ifdef DUMP_CHECKSUM_EN
    assign bus.o_tx_valid = (r_state == ST_SEND) || (r_state == ST_CHK);
`else
    assign bus.o_tx_valid = (r_state == ST_SEND);
`endif
    assign bus.o_busy     = (r_state != ST_IDLE);
    assign bus.o_done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_debug_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_mem_dump
//  Description : Directed self-checking bench for debug_mem_dump. Works in
//                both builds; expectations follow DUMP_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debug_mem_dump;

`ifdef DUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk;
    logic reset;
    logic [7:0] mem [0:4095];

    int n_checks;
    int n_errors;

    logic [7:0] rx_data[$];
    int         rx_cyc[$];
    int         done_cyc;
    logic       busy_c1;

    debug_mem_dump_if #(.ADDR_WIDTH(12)) bus ();

    debug_mem_dump #(.ADDR_WIDTH(12)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Asynchronous memory model.
    assign bus.i_mem_data = mem[bus.o_mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle 0 = the cycle in which start is sampled. Inputs are driven and
    // outputs sampled at the falling edge. Ready is dropped for the first
    // 'stall' cycles in which valid is seen, with hold checks on each.
    task automatic run_dump(input logic [11:0] base, input logic [12:0] len, input int stall);
        int         cyc;
        int         left;
        logic [7:0] hd;
        logic [11:0] ha;
        bit         hv;
        rx_data.delete();
        rx_cyc.delete();
        done_cyc = -1;
        left     = stall;
        hv       = 1'b0;
        hd       = 8'h00;
        ha       = 12'h000;
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        bus.i_length    = len;
        bus.i_tx_ready  = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cyc = 1;
        busy_c1 = bus.o_busy;
        while (done_cyc < 0 && cyc < 100) begin
            if (bus.o_done) done_cyc = cyc;
            if (bus.o_tx_valid) begin
                if (left > 0) begin
                    if (hv) begin
                        check("hold_data", bus.o_tx_data, hd);
                        check("hold_addr", bus.o_mem_addr, ha);
                    end else begin
                        hd = bus.o_tx_data;
                        ha = bus.o_mem_addr;
                        hv = 1'b1;
                    end
                    left--;
                    bus.i_tx_ready = 1'b0;
                end else begin
                    bus.i_tx_ready = 1'b1;
                    rx_data.push_back(bus.o_tx_data);
                    rx_cyc.push_back(cyc);
                end
            end else begin
                bus.i_tx_ready = 1'b1;
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
        @(negedge clk);
        check("done_one_cycle", bus.o_done, 1'b0);
        check("busy_after_done", bus.o_busy, 1'b0);
    endtask

    // exp_bytes holds data byte i in bits [8*i +: 8].
    task automatic verify(input string tag, input int len, input int stall, input logic [31:0] exp_bytes);
        int         n;
        logic [7:0] cs;
        logic [7:0] e;
        n  = len + ((CS && len > 0) ? 1 : 0);
        cs = 8'h00;
        check({tag, "_count"}, rx_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < len) e = exp_bytes[8*i +: 8];
            else         e = cs;
            cs = cs ^ e;
            if (i < rx_data.size()) begin
                check($sformatf("%s_byte%0d", tag, i), rx_data[i], e);
                check($sformatf("%s_cyc%0d", tag, i), rx_cyc[i], 2 + 2*i + stall);
            end
        end
        check({tag, "_done_cyc"}, done_cyc, n + len + 1 + stall);
        check({tag, "_busy_c1"}, busy_c1, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'h11; mem[12'h011] = 8'h22;
        mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
        mem[12'hFFE] = 8'hAA; mem[12'hFFF] = 8'hBB;
        mem[12'h000] = 8'hCC; mem[12'h001] = 8'hDD;
        mem[12'h020] = 8'h5A; mem[12'h021] = 8'hA5;

        reset           = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_base_addr = 12'h000;
        bus.i_length    = 13'h0000;
        bus.i_tx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_tx_valid, 1'b0);
        check("rst_data",  bus.o_tx_data,  8'h00);
        check("rst_busy",  bus.o_busy,     1'b0);
        check("rst_done",  bus.o_done,     1'b0);
        check("rst_addr",  bus.o_mem_addr, 12'h000);
        reset = 1'b0;

        // Plain four-byte dump, ready high.
        run_dump(12'h010, 13'd4, 0);
        verify("t1", 4, 0, {8'h44, 8'h33, 8'h22, 8'h11});

        // Dump across the top of memory.
        run_dump(12'hFFE, 13'd4, 0);
        verify("t3", 4, 0, {8'hDD, 8'hCC, 8'hBB, 8'hAA});

        // Back-pressure on the first byte for five cycles.
        run_dump(12'h020, 13'd2, 5);
        verify("t4", 2, 5, {16'h0000, 8'hA5, 8'h5A});

        // Empty dump.
        run_dump(12'h123, 13'd0, 0);
        verify("t5", 0, 0, 32'h0);

        // Start pulse mid-dump, then reset while a byte is pending.
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_base_addr = 12'h010;
        bus.i_length    = 13'd4;
        bus.i_tx_ready  = 1'b1;
        @(negedge clk);                 // cycle 1
        bus.i_start = 1'b0;
        @(negedge clk);                 // cycle 2
        @(negedge clk);                 // cycle 3
        bus.i_start     = 1'b1;
        bus.i_base_addr = 12'h000;
        bus.i_length    = 13'd0;
        @(negedge clk);                 // cycle 4
        bus.i_start = 1'b0;
        check("t6_valid",  bus.o_tx_valid, 1'b1);
        check("t6_data",   bus.o_tx_data,  8'h22);
        check("t6_addr",   bus.o_mem_addr, 12'h011);
        check("t6_busy",   bus.o_busy,     1'b1);
        bus.i_tx_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", bus.o_tx_valid, 1'b0);
        check("t6_rst_data",  bus.o_tx_data,  8'h00);
        check("t6_rst_busy",  bus.o_busy,     1'b0);
        check("t6_rst_done",  bus.o_done,     1'b0);
        check("t6_rst_addr",  bus.o_mem_addr, 12'h000);
        reset = 1'b0;
        run_dump(12'h010, 13'd4, 0);
        verify("t6", 4, 0, {8'h44, 8'h33, 8'h22, 8'h11});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
